// File: rtl/rst_code_decoder.sv
// rst_code_decoder: receiver for the serial reset-code line from the sync board.
// Finds 4-bit frame alignment, qualifies lock and converts ACTIVE codes into a
// stretched synchronous reset pulse.
// Optional feature macro: RST_DECODER_ERR_COUNT_EN (builds the err_count counter).
module rst_code_decoder #(
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned RST_HOLD     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_line,
    output logic        locked,
    output logic        sync_rst,
    output logic        frame_strobe,
    output logic [15:0] err_count
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [3:0] CODE_IDLE   = 4'b1010;
    localparam logic [3:0] CODE_ACTIVE = 4'b1100;
    localparam logic [3:0] CODE_SLIP   = 4'b1011;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t              state, state_d;
    logic [3:0]          s, s_d;
    logic [1:0]          ph, ph_d;
    logic [GOOD_W-1:0]   good, good_d;
    logic [BAD_W-1:0]    bad, bad_d;
    logic [HOLD_W-1:0]   hold, hold_d;
    logic                pending, pending_d;
    logic                strobe_d;
    logic                count_err;
    logic                boundary;
    logic                realign;
    logic                w_valid;

    // Next-state: alignment search, lock qualification, ACTIVE/slip handling
    always_comb begin
        state_d   = state;
        s_d       = {s[2:0], rst_line};
        ph_d      = ph + 2'd1;
        good_d    = good;
        bad_d     = bad;
        hold_d    = (hold != '0) ? hold - HOLD_W'(1) : hold;
        pending_d = pending;
        count_err = 1'b0;
        realign   = 1'b0;
        boundary  = (ph == 2'd3);
        w_valid   = (s == CODE_IDLE) || (s == CODE_ACTIVE);

        case (state)
            HUNT: begin
                bad_d     = '0;
                pending_d = 1'b0;
                if (w_valid) begin
                    ph_d    = 2'd0;
                    good_d  = GOOD_W'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                bad_d = '0;
                if (boundary) begin
                    if (w_valid) begin
                        good_d = good + GOOD_W'(1);
                        if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (s == CODE_ACTIVE) begin
                    realign   = 1'b1;
                    ph_d      = 2'd0;
                    bad_d     = '0;
                    pending_d = 1'b0;
                    hold_d    = HOLD_W'(RST_HOLD);
                end else if (pending && (ph == 2'd1)) begin
                    pending_d = 1'b0;
                    count_err = 1'b1;
                end else if (boundary) begin
                    if (s == CODE_IDLE) begin
                        bad_d = '0;
                    end else if (s == CODE_SLIP) begin
                        pending_d = 1'b1;
                    end else begin
                        count_err = 1'b1;
                    end
                end
                if (count_err) begin
                    if (bad == BAD_W'(UNLOCK_COUNT - 1)) begin
                        state_d   = HUNT;
                        bad_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        bad_d = bad + BAD_W'(1);
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        strobe_d = (state_d == LOCKED) && (boundary || realign);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            s            <= '0;
            ph           <= '0;
            good         <= '0;
            bad          <= '0;
            hold         <= '0;
            pending      <= 1'b0;
            locked       <= 1'b0;
            sync_rst     <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            state        <= state_d;
            s            <= s_d;
            ph           <= ph_d;
            good         <= good_d;
            bad          <= bad_d;
            hold         <= hold_d;
            pending      <= pending_d;
            locked       <= (state_d == LOCKED);
            sync_rst     <= (hold_d != '0);
            frame_strobe <= strobe_d;
        end
    end

`ifdef RST_DECODER_ERR_COUNT_EN
    logic [15:0] err_q;

    // Saturating count of invalid codes seen while locked
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (count_err && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_rst_code_decoder.sv
// Testbench for rst_code_decoder: randomized code stream with a frame-level
// reference model feeding a scoreboard queue, compared every cycle by a monitor.
module tb_rst_code_decoder;

    localparam int unsigned LOCK_COUNT   = 8;
    localparam int unsigned UNLOCK_COUNT = 4;
    localparam int unsigned RST_HOLD     = 16;

`ifdef RST_DECODER_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [3:0] C_IDLE   = 4'b1010;
    localparam logic [3:0] C_ACTIVE = 4'b1100;
    localparam logic [3:0] C_SLIP   = 4'b1011;
    localparam logic [3:0] C_ZERO   = 4'b0000;

    localparam int M_HUNT  = 0;
    localparam int M_CHECK = 1;
    localparam int M_LOCK  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_line = 1'b0;
    logic        locked;
    logic        sync_rst;
    logic        frame_strobe;
    logic [15:0] err_count;

    typedef struct packed {
        logic        locked;
        logic        sync_rst;
        logic        strobe;
        logic [15:0] err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    passed = 0;

    // reference model state: absolute cycle bookkeeping instead of a phase counter
    int m_mode, m_cyc, m_next_b, m_good, m_bad, m_pend_due, m_rst_end, m_err;
    bit m_bits[$];

    // lock-time measurement
    int since_rel  = 0;
    int first_lock = -1;

    always #5 clk = ~clk;

    rst_code_decoder #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_line    (rst_line),
        .locked      (locked),
        .sync_rst    (sync_rst),
        .frame_strobe(frame_strobe),
        .err_count   (err_count)
    );

    // Reference model: one call per clock edge, pushes the response expected after it
    task automatic model_step(input bit r, input bit b);
        resp_t      e;
        logic [3:0] w;
        bit         is_b, realign, err_now, valid;
        if (r) begin
            m_mode     = M_HUNT;
            m_cyc      = 0;
            m_next_b   = 3;
            m_good     = 0;
            m_bad      = 0;
            m_pend_due = -1;
            m_rst_end  = -1;
            m_err      = 0;
            m_bits.delete();
            repeat (4) m_bits.push_back(1'b0);
            e = '0;
            exp_q.push_back(e);
            return;
        end
        w       = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
        is_b    = (m_cyc == m_next_b);
        if (is_b) m_next_b = m_cyc + 4;
        valid   = (w == C_IDLE) || (w == C_ACTIVE);
        realign = 1'b0;
        err_now = 1'b0;
        case (m_mode)
            M_HUNT: begin
                if (valid) begin
                    m_next_b = m_cyc + 4;
                    m_good   = 1;
                    m_mode   = M_CHECK;
                end
            end
            M_CHECK: begin
                if (is_b) begin
                    if (valid) begin
                        m_good++;
                        if (m_good >= int'(LOCK_COUNT)) begin
                            m_mode = M_LOCK;
                            m_bad  = 0;
                        end
                    end else begin
                        m_mode = M_HUNT;
                    end
                end
            end
            default: begin
                if (w == C_ACTIVE) begin
                    realign    = 1'b1;
                    m_next_b   = m_cyc + 4;
                    m_bad      = 0;
                    m_pend_due = -1;
                    m_rst_end  = m_cyc + int'(RST_HOLD);
                end else if (m_pend_due == m_cyc) begin
                    m_pend_due = -1;
                    err_now    = 1'b1;
                end else if (is_b) begin
                    if (w == C_IDLE)      m_bad = 0;
                    else if (w == C_SLIP) m_pend_due = m_cyc + 2;
                    else                  err_now = 1'b1;
                end
                if (err_now) begin
                    m_bad++;
                    if (ERR_EN && m_err < 65535) m_err++;
                    if (m_bad >= int'(UNLOCK_COUNT)) begin
                        m_mode     = M_HUNT;
                        m_pend_due = -1;
                    end
                end
            end
        endcase
        m_bits.push_back(b);
        void'(m_bits.pop_front());
        m_cyc++;
        e.locked   = (m_mode == M_LOCK);
        e.sync_rst = (m_cyc <= m_rst_end);
        e.strobe   = (m_mode == M_LOCK) && (is_b || realign);
        e.err      = 16'(m_err);
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input bit r, input bit b);
        @(negedge clk);
        rst      = r;
        rst_line = b;
        model_step(r, b);
    endtask

    task automatic send_code(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) drive_bit(1'b0, c[i]);
    endtask

    task automatic send_idles(input int n);
        repeat (n) send_code(C_IDLE);
    endtask

    // Monitor: compare DUT outputs against the scoreboard once per cycle
    initial begin
        resp_t e;
        resp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (rst) since_rel = 0;
            else     since_rel++;
            if (first_lock < 0 && locked === 1'b1) first_lock = since_rel;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {locked, sync_rst, frame_strobe, err_count};
                checks++;
                if (a === e) passed++;
                else $display("FAIL cycle_check t=%0t got locked=%b sync_rst=%b strobe=%b err=%0d expected locked=%b sync_rst=%b strobe=%b err=%0d",
                              $time, a.locked, a.sync_rst, a.strobe, a.err,
                              e.locked, e.sync_rst, e.strobe, e.err);
            end
        end
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int r;
        int exp_lock;
        repeat (3) drive_bit(1'b1, 1'b0);

        // clean IDLE lock
        send_idles(12);

        // single ACTIVE
        send_code(C_ACTIVE);
        send_idles(8);

        // 2-bit slip of the stream, then ACTIVE on the new framing
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        send_idles(3);
        send_code(C_ACTIVE);
        send_idles(8);

        // three errors keep lock, four drop it, then re-lock
        repeat (3) send_code(C_ZERO);
        send_idles(4);
        repeat (4) send_code(C_ZERO);
        send_idles(12);

        // two ACTIVE codes 8 cycles apart merge into one pulse
        send_code(C_ACTIVE);
        send_code(C_IDLE);
        send_code(C_ACTIVE);
        send_idles(8);

        // reset in the middle of a sync_rst pulse
        send_code(C_ACTIVE);
        send_code(C_IDLE);
        drive_bit(1'b1, 1'b0);
        send_idles(12);

        // randomized mix
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send_code(C_IDLE);
            else if (r < 72) send_code(C_ACTIVE);
            else if (r < 84) send_code(4'($urandom));
            else if (r < 92) begin
                drive_bit(1'b0, 1'b1);
                drive_bit(1'b0, 1'b0);
            end else drive_bit(1'b0, 1'($urandom));
        end
        send_idles(12);

        @(posedge clk);
        #2;

        exp_lock = 4 + 4 * (int'(LOCK_COUNT) - 1) + 1;
        checks++;
        if (first_lock == exp_lock) passed++;
        else $display("FAIL lock_time got=%0d expected=%0d", first_lock, exp_lock);

        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
